hwpe_stream_addressgen_nd: RTL and testbench
============================================

# hwpe_stream_addressgen_nd

N-dimensional, parametrised address generator for HWPE streamers.
- Produces one byte address per accepted beat on a valid/ready handshake; each beat is a base address plus per-dimension strided offsets.
- Supports a configurable number of nested loop dimensions, signed strides, roll-over when all dimensions wrap, and per-dimension wrap flags.
- Sits between the engine controller (configuration, start/done) and the source/sink TCDM request logic.

## Interface
- NB_DIMS, 3: number of nested loop dimensions (1..8); index 0 is innermost.
- ADDR_WIDTH, 32: address width in bits.
- CNT_WIDTH, 16: per-dimension length counter width.
- STRIDE_WIDTH, 16: per-dimension stride width, signed two's complement.
- Reset: one clock; reset is synchronous and active-high.
- clk_i  in  1  clock; all state changes on the rising edge.
- clear_i  in  1  synchronous active-high reset.
- start_i  in  1  start request; sampled only in IDLE.
- base_addr_i  in  ADDR_WIDTH  first address; latched on start.
- trans_size_i  in  32  total beats to issue; latched on start.
- length_i  in  NB_DIMS×CNT_WIDTH  iterations per dimension; latched on start.
- stride_i  in  NB_DIMS×STRIDE_WIDTH  signed byte stride per dimension; latched on start.
- addr_valid_o  out  1  address beat valid.
- addr_ready_i  in  1  downstream accepts beat.
- addr_o  out  ADDR_WIDTH  current address.
- last_o  out  1  current beat is the final beat of the transfer.
- wrap_o  out  NB_DIMS  bit d high when the current beat is the last iteration of dimensions 0..d.
- busy_o  out  1  state is WORKING or DONE.
- done_o  out  1  one-cycle pulse after the final beat is accepted.

## Operation
- States: the state enum is state_sourcesink_t, with values STREAM_IDLE, STREAM_WORKING and STREAM_DONE.
- IDLE + start_i, trans_size_i≠0:
  - latch the configuration;
  - clear all counters c[d] and offsets off[d];
  - go to WORKING.
- IDLE + start_i, trans_size_i=0: go straight to DONE; no beats are issued.
- WORKING:
  - addr_valid_o=1;
  - addr_o = base + Σ off[d], computed combinationally from registers, modulo 2^ADDR_WIDTH.
- Handshake (addr_valid_o & addr_ready_i) advances the loop state:
  - increment the beat counter;
  - find the lowest d with c[d] < len[d]−1;
  - set c[d]++ and off[d] += sext(stride[d]);
  - for all j<d, set c[j]=0 and off[j]=0.
- All-dimension wrap: if every dimension is at its last iteration, clear all c and off. The address rolls back to base and the transfer continues until trans_size beats are done.
- Final beat: the handshake with beat counter = trans_size−1 moves WORKING→DONE.
- DONE: done_o=1 for exactly one cycle, then IDLE. start_i is ignored in WORKING and DONE.
- Zero length: length 0 on any dimension is treated as 1.
- Arithmetic: strides are sign-extended to ADDR_WIDTH. Offset and address arithmetic wraps modulo 2^ADDR_WIDTH; there is no overflow flag.
- Beat counter: 32 bits.
- Flag outputs: wrap_o and last_o are valid only while addr_valid_o=1 and are 0 otherwise.

## Timing
- Reset values (after clear_i): state IDLE, all counters and offsets 0, addr_valid_o=0, addr_o=0, last_o=0, wrap_o=0, busy_o=0, done_o=0.
- Start latency: start_i in cycle t gives addr_valid_o=1 and addr_o=base in cycle t+1.
- Throughput: one address per cycle while addr_ready_i=1.
- Handshake rules:
  - addr_valid_o never drops without a handshake while in WORKING;
  - addr_o, last_o and wrap_o stay stable while addr_ready_i=0.
- End of transfer: final handshake at cycle t, then done_o=1 at t+1, then IDLE at t+2. The earliest next start is sampled at t+2.
- Zero-size transfer: start at t, done_o at t+1.
- Clear precedence: clear_i wins over every other event in the same cycle. If asserted mid-transfer, the next cycle is IDLE with outputs at reset values and no done_o pulse.

## Structure
- hwpe_stream_package receives:
  - HWPE_STREAM_ADDRGEN_MAX_DIMS = 8;
  - a typedef ctrl_addressgen_nd_t, built with the default widths and MAX_DIMS, for register-file mapping.
- State type: reuse state_sourcesink_t.
- Sub-module hwpe_stream_addressgen_nd_dim, one instance per dimension:
  - holds the counter c[d] and offset off[d];
  - inputs: step, clear-lower, len, stride;
  - outputs: at_last and off.
- The top level owns the FSM, the carry-chain priority logic, the beat counter and the address adder.

## Test plan
- 1-D run: base=0x1000, len0=4, stride0=4, trans=4, ready=1 → addresses 0x1000, 0x1004, 0x1008, 0x100C; last_o on 0x100C; done_o one cycle later.
- 2-D negative stride, NB_DIMS=2: len={3,2}, stride={−4,0x100}, base=0x2008 → 0x2008, 0x2004, 0x2000, 0x2108, 0x2104, 0x2100. wrap_o[0] is set on 0x2000 and 0x2100; wrap_o[1] is set on 0x2100.
- Roll-over: len0=2, stride0=8, trans=5, base=0 → 0, 8, 0, 8, 0; last_o on the 5th beat.
- Backpressure: addr_ready_i is toggled randomly → addr_o and flags are held while not ready; the sequence matches the ready=1 run.
- Boundary: trans=0 → no addr_valid_o and done_o at t+1. Separately, length=0 behaves as length=1, and base=0xFFFFFFFC with stride=8 wraps to 0x00000004.
- Clear: clear_i asserted after 2 of 6 beats → next cycle IDLE with all outputs 0 and no done_o. A new start then restarts from base.

Source files
------------

// File: rtl/hwpe_stream_package.sv
// hwpe_stream_package: shared types and constants for HWPE streamers
package hwpe_stream_package;
  localparam int unsigned HWPE_STREAM_ADDRGEN_MAX_DIMS = 8;
  localparam int unsigned HWPE_STREAM_ADDRGEN_ADDR_WIDTH = 32;
  localparam int unsigned HWPE_STREAM_ADDRGEN_CNT_WIDTH = 16;
  localparam int unsigned HWPE_STREAM_ADDRGEN_STRIDE_WIDTH = 16;
  typedef enum logic [1:0] {
    STREAM_IDLE,
    STREAM_WORKING,
    STREAM_DONE
  } state_sourcesink_t;
  typedef struct packed {
    logic [HWPE_STREAM_ADDRGEN_ADDR_WIDTH-1:0] base_addr;
    logic [31:0] trans_size;
    logic [HWPE_STREAM_ADDRGEN_MAX_DIMS*HWPE_STREAM_ADDRGEN_CNT_WIDTH-1:0] length;
    logic [HWPE_STREAM_ADDRGEN_MAX_DIMS*HWPE_STREAM_ADDRGEN_STRIDE_WIDTH-1:0] stride;
  } ctrl_addressgen_nd_t;
endpackage

// File: rtl/hwpe_stream_addressgen_nd_dim.sv
// hwpe_stream_addressgen_nd_dim: iteration counter and strided offset for one loop dimension
module hwpe_stream_addressgen_nd_dim
  import hwpe_stream_package::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned STRIDE_WIDTH = 16
) (
  input  logic                    clk_i,
  input  logic                    clear_i,
  input  logic                    step_i,
  input  logic                    clr_lower_i,
  input  logic [CNT_WIDTH-1:0]    len_i,
  input  logic [STRIDE_WIDTH-1:0] stride_i,
  output logic                    at_last_o,
  output logic [ADDR_WIDTH-1:0]   off_o
);
  logic [CNT_WIDTH-1:0] c_q, c_d;
  logic [ADDR_WIDTH-1:0] off_q, off_d;
  // c+1 >= len makes a zero length behave as a single iteration
  assign at_last_o = ({1'b0, c_q} + (CNT_WIDTH+1)'(1)) >= {1'b0, len_i};
  assign off_o = off_q;
  // clearing (carry wrap or new transfer) has priority over stepping
  always_comb begin
    c_d = clr_lower_i ? '0 : step_i ? c_q + CNT_WIDTH'(1) : c_q;
    off_d = clr_lower_i ? '0 : step_i ? off_q + {{(ADDR_WIDTH-STRIDE_WIDTH){stride_i[STRIDE_WIDTH-1]}}, stride_i} : off_q;
  end
  // counter and offset registers
  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      c_q <= '0;
      off_q <= '0;
    end else begin
      c_q <= c_d;
      off_q <= off_d;
    end
  end
endmodule

// File: rtl/hwpe_stream_addressgen_nd.sv
// hwpe_stream_addressgen_nd: N-dimensional strided byte address generator with valid/ready output
module hwpe_stream_addressgen_nd
  import hwpe_stream_package::*;
#(
  parameter int unsigned NB_DIMS = 3,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned STRIDE_WIDTH = 16
) (
  input  logic                            clk_i,
  input  logic                            clear_i,
  input  logic                            start_i,
  input  logic [ADDR_WIDTH-1:0]           base_addr_i,
  input  logic [31:0]                     trans_size_i,
  input  logic [NB_DIMS*CNT_WIDTH-1:0]    length_i,
  input  logic [NB_DIMS*STRIDE_WIDTH-1:0] stride_i,
  output logic                            addr_valid_o,
  input  logic                            addr_ready_i,
  output logic [ADDR_WIDTH-1:0]           addr_o,
  output logic                            last_o,
  output logic [NB_DIMS-1:0]              wrap_o,
  output logic                            busy_o,
  output logic                            done_o
);
  state_sourcesink_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d, sum;
  logic [31:0] trans_q, trans_d, beat_q, beat_d;
  logic [NB_DIMS*CNT_WIDTH-1:0] len_q, len_d;
  logic [NB_DIMS*STRIDE_WIDTH-1:0] stride_q, stride_d;
  logic [NB_DIMS-1:0] at_last, step, clr_lower, wrap;
  logic [ADDR_WIDTH-1:0] off [NB_DIMS];
  logic launch, hs, final_beat, carry;
  assign launch = state_q == STREAM_IDLE && start_i && trans_size_i != 32'd0;
  assign hs = addr_valid_o && addr_ready_i;
  assign final_beat = hs && last_o;
  // state register
  always_ff @(posedge clk_i) begin
    if (clear_i) state_q <= STREAM_IDLE;
    else state_q <= state_d;
  end
  // next state: zero-size starts skip straight to DONE, DONE lasts one cycle
  always_comb begin
    state_d = state_q == STREAM_IDLE ? (start_i ? (trans_size_i != 32'd0 ? STREAM_WORKING : STREAM_DONE) : STREAM_IDLE)
            : state_q == STREAM_WORKING ? (final_beat ? STREAM_DONE : STREAM_WORKING)
            : STREAM_IDLE;
  end
  // configuration is captured once per transfer, beat counter restarts on launch
  always_comb begin
    base_d = launch ? base_addr_i : base_q;
    trans_d = launch ? trans_size_i : trans_q;
    len_d = launch ? length_i : len_q;
    stride_d = launch ? stride_i : stride_q;
    beat_d = launch ? '0 : hs ? beat_q + 32'd1 : beat_q;
  end
  // configuration and beat counter registers
  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      base_q <= '0;
      trans_q <= '0;
      len_q <= '0;
      stride_q <= '0;
      beat_q <= '0;
    end else begin
      base_q <= base_d;
      trans_q <= trans_d;
      len_q <= len_d;
      stride_q <= stride_d;
      beat_q <= beat_d;
    end
  end
  // carry chain: lowest non-final dimension steps, every dimension below it (all, on full wrap) clears
  always_comb begin
    carry = 1'b1;
    for (int i = 0; i < NB_DIMS; i++) begin
      step[i] = hs && carry && !at_last[i];
      carry = carry && at_last[i];
      wrap[i] = carry;
      clr_lower[i] = launch || (hs && carry);
    end
  end
  // address adder, modulo 2^ADDR_WIDTH
  always_comb begin
    sum = base_q;
    for (int i = 0; i < NB_DIMS; i++) sum = sum + off[i];
  end
  // outputs read as zero outside WORKING so idle and done look like reset
  always_comb begin
    addr_valid_o = state_q == STREAM_WORKING;
    addr_o = addr_valid_o ? sum : '0;
    last_o = addr_valid_o && beat_q == trans_q - 32'd1;
    wrap_o = addr_valid_o ? wrap : '0;
    busy_o = state_q != STREAM_IDLE;
    done_o = state_q == STREAM_DONE;
  end
  for (genvar d = 0; d < NB_DIMS; d++) begin : g_dim
    hwpe_stream_addressgen_nd_dim #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .CNT_WIDTH(CNT_WIDTH),
      .STRIDE_WIDTH(STRIDE_WIDTH)
    ) i_dim (
      .clk_i(clk_i),
      .clear_i(clear_i),
      .step_i(step[d]),
      .clr_lower_i(clr_lower[d]),
      .len_i(len_q[d*CNT_WIDTH +: CNT_WIDTH]),
      .stride_i(stride_q[d*STRIDE_WIDTH +: STRIDE_WIDTH]),
      .at_last_o(at_last[d]),
      .off_o(off[d])
    );
  end
endmodule

// File: tb/tb_hwpe_stream_addressgen_nd.sv
// tb_hwpe_stream_addressgen_nd: scoreboard bench against a mixed-radix loop-nest model
module tb_hwpe_stream_addressgen_nd;
  localparam int NB = 3;
  localparam int CW = 16;
  localparam int SW = 16;
  typedef struct packed {
    logic [31:0] a;
    logic l;
    logic [NB-1:0] w;
  } beat_t;
  logic clk = 1'b0;
  logic clear, start, ready, valid, last, busy, done;
  logic [31:0] base, trans, addr;
  logic [NB*CW-1:0] len;
  logic [NB*SW-1:0] strd;
  logic [NB-1:0] wrap;
  beat_t q[$];
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  hwpe_stream_addressgen_nd #(.NB_DIMS(NB), .ADDR_WIDTH(32), .CNT_WIDTH(CW), .STRIDE_WIDTH(SW)) dut (
    .clk_i(clk),
    .clear_i(clear),
    .start_i(start),
    .base_addr_i(base),
    .trans_size_i(trans),
    .length_i(len),
    .stride_i(strd),
    .addr_valid_o(valid),
    .addr_ready_i(ready),
    .addr_o(addr),
    .last_o(last),
    .wrap_o(wrap),
    .busy_o(busy),
    .done_o(done)
  );
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  // beat k of the loop nest: digits of k in the mixed radix given by the lengths (0 counts as 1)
  task automatic expect_run(input logic [31:0] b, input logic [31:0] n, input int l[NB], input int s[NB]);
    for (longint k = 0; k < longint'(n); k++) begin
      longint r = k;
      longint idx;
      longint e;
      bit all = 1'b1;
      beat_t x;
      x.a = b;
      for (int i = 0; i < NB; i++) begin
        e = l[i] == 0 ? 1 : l[i];
        idx = r % e;
        r = r / e;
        x.a = x.a + 32'(idx * longint'(s[i]));
        all = all && idx == e - 1;
        x.w[i] = all;
      end
      x.l = k == longint'(n) - 1;
      q.push_back(x);
    end
  endtask
  task automatic drive_cfg(input logic [31:0] b, input logic [31:0] n, input int l[NB], input int s[NB]);
    base = b;
    trans = n;
    for (int i = 0; i < NB; i++) begin
      len[i*CW +: CW] = CW'(l[i]);
      strd[i*SW +: SW] = SW'(s[i]);
    end
  endtask
  task automatic run(input logic [31:0] b, input logic [31:0] n, input int l[NB], input int s[NB], input bit bp);
    bit got = 1'b0;
    expect_run(b, n, l, s);
    drive_cfg(b, n, l, s);
    start = 1'b1;
    ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (n != 0) begin
      chk("start_valid", valid, 1);
      chk("start_addr", addr, b);
    end else begin
      chk("zero_no_valid", valid, 0);
      chk("zero_done", done, 1);
    end
    for (int c = 0; c < 5000 && !got; c++) begin
      if (done) got = 1'b1;
      else begin
        ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk);
        #1;
      end
    end
    chk("done_seen", got, 1);
    chk("queue_drained", q.size(), 0);
    q.delete();
    @(posedge clk);
    #1;
    chk("idle_after_done", busy, 0);
  endtask
  logic exp_done = 1'b0;
  bit stall = 1'b0;
  beat_t held;
  // monitor: pops the scoreboard on each handshake, checks holds under backpressure and done timing
  always @(negedge clk) begin : mon
    beat_t x;
    logic el;
    el = 1'b0;
    chk("done_timing", done, exp_done);
    if (stall) begin
      chk("hold_valid", valid, 1);
      chk("hold_addr", addr, held.a);
      chk("hold_last", last, held.l);
      chk("hold_wrap", wrap, held.w);
    end
    if (valid && ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got addr %0h with empty scoreboard", addr);
      end else begin
        checks++;
        x = q.pop_front();
        chk("addr", addr, x.a);
        chk("last", last, x.l);
        chk("wrap", wrap, x.w);
        el = x.l;
      end
    end
    if (!valid) begin
      chk("idle_last", last, 0);
      chk("idle_wrap", wrap, 0);
    end
    stall = valid && !ready && !clear;
    held = {addr, last, wrap};
    exp_done = !clear && ((valid && ready && el) || (start && trans == 0 && !busy));
  end
  initial begin
    clear = 1'b1;
    start = 1'b0;
    ready = 1'b0;
    base = '0;
    trans = '0;
    len = '0;
    strd = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", valid, 0);
    chk("rst_addr", addr, 0);
    chk("rst_last", last, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    clear = 1'b0;
    run(32'h1000, 4, '{4, 1, 1}, '{4, 0, 0}, 1'b0);
    run(32'h2008, 6, '{3, 2, 1}, '{-4, 'h100, 0}, 1'b0);
    run(32'h0, 5, '{2, 1, 1}, '{8, 0, 0}, 1'b0);
    run(32'h2008, 6, '{3, 2, 1}, '{-4, 'h100, 0}, 1'b1);
    run(32'h1000, 0, '{4, 1, 1}, '{4, 0, 0}, 1'b0);
    run(32'hFFFF_FFFC, 2, '{2, 1, 1}, '{8, 0, 0}, 1'b0);
    run(32'h40, 4, '{0, 3, 0}, '{4, 'h10, 0}, 1'b0);
    expect_run(32'h3000, 6, '{3, 2, 1}, '{4, 'h40, 0});
    drive_cfg(32'h3000, 6, '{3, 2, 1}, '{4, 'h40, 0});
    start = 1'b1;
    ready = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    chk("clr_valid", valid, 0);
    chk("clr_addr", addr, 0);
    chk("clr_last", last, 0);
    chk("clr_wrap", wrap, 0);
    chk("clr_busy", busy, 0);
    chk("clr_done", done, 0);
    q.delete();
    @(posedge clk);
    #1;
    chk("clr_no_done", done, 0);
    run(32'h3000, 6, '{3, 2, 1}, '{4, 'h40, 0}, 1'b0);
    for (int r = 0; r < 10; r++) begin
      int l[NB];
      int s[NB];
      for (int i = 0; i < NB; i++) begin
        l[i] = int'($urandom_range(0, 4));
        s[i] = int'($signed(16'($urandom)));
      end
      run($urandom, $urandom_range(0, 40), l, s, r[0]);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
